// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI receive deserializer.
// Defining SPI_RX_GLITCH_FILTER_EN enables the SCLK/CS glitch filter (+2 cycles latency).
package spi_rx_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    HOLD      = 2'd3
  } rx_state_e;

  localparam int DEFAULT_DATASIZE = 16;
  localparam int FILTER_DEPTH     = 3;

`ifdef SPI_RX_GLITCH_FILTER_EN
  localparam int FILTER_LATENCY = FILTER_DEPTH - 1;
`else
  localparam int FILTER_LATENCY = 0;
`endif

  // Cycles CS must read high before leaving WAIT_IDLE; longer than the time the
  // reset-loaded '1' takes to drain out of the CS pipeline.
  function automatic int settle_cycles(input int sync_stages);
    return sync_stages + 3 + FILTER_LATENCY;
  endfunction

endpackage

// File: rtl/spi_rx_pin_sync.sv
// Pin synchronizer with optional 3-sample glitch filter and registered rise/fall pulses.
// Non-filtered instances are delayed by the same amount so all pins stay aligned.
module spi_rx_pin_sync
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit RST_VAL     = 1'b0,
  parameter bit FILTER      = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_w;
  logic                   eff_d;
  logic                   level_q;
  logic                   rise_q;
  logic                   fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign sync_w = sync_q[SYNC_STAGES-1];

  if (FILTER) begin : g_filter_path
    if (FILTER_LATENCY == 0) begin : g_direct
      assign eff_d = sync_w;
    end else begin : g_filt
      logic [FILTER_LATENCY-1:0] hist_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          hist_q <= {FILTER_LATENCY{RST_VAL}};
        end else begin
          hist_q <= {hist_q[FILTER_LATENCY-2:0], sync_w};
        end
      end
      // Accept a new level only once it has been seen on FILTER_DEPTH consecutive samples.
      assign eff_d = (hist_q == {FILTER_LATENCY{sync_w}}) ? sync_w : level_q;
    end
  end else begin : g_plain_path
    if (FILTER_LATENCY == 0) begin : g_direct
      assign eff_d = sync_w;
    end else begin : g_delay
      logic [FILTER_LATENCY-1:0] hist_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          hist_q <= {FILTER_LATENCY{RST_VAL}};
        end else begin
          hist_q <= {hist_q[FILTER_LATENCY-2:0], sync_w};
        end
      end
      assign eff_d = hist_q[FILTER_LATENCY-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= eff_d;
      rise_q  <= eff_d & ~level_q;
      fall_q  <= ~eff_d & level_q;
    end
  end

  // level_o is the value from the same cycle in which rise_o/fall_o are computed.
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/spi_receive_deserializer.sv
// SPI slave receiver: oversamples SCLK/MOSI/CS, deserializes one MSB-first word per CS frame,
// presents it on valid/ready and flags framing errors/overruns. SPI_RX_GLITCH_FILTER_EN adds the pin filter.
module spi_receive_deserializer
  import spi_rx_pkg::*;
#(
  parameter int DATASIZE    = DEFAULT_DATASIZE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_SCLK,
  input  logic                i_MOSI,
  input  logic                i_CS,
  input  logic                i_EdgeShape,
  input  logic                i_Ready,
  output logic [DATASIZE-1:0] o_Data,
  output logic                o_Valid,
  output logic                o_FrameErr,
  output logic                o_Overrun,
  output logic                o_Busy
);

  localparam int CW     = $clog2(DATASIZE + 1);
  localparam int SETTLE = settle_cycles(SYNC_STAGES);
  localparam int WW     = $clog2(SETTLE + 1);

  logic sclk_rise, sclk_fall, sclk_level_unused;
  logic cs_rise, cs_fall, cs_level;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic sample;

  spi_rx_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .FILTER(1'b1)) u_sclk_sync (
    .clk_i(i_Clk), .rst_ni(i_Rst_L), .pin_i(i_SCLK),
    .level_o(sclk_level_unused), .rise_o(sclk_rise), .fall_o(sclk_fall)
  );

  spi_rx_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1), .FILTER(1'b1)) u_cs_sync (
    .clk_i(i_Clk), .rst_ni(i_Rst_L), .pin_i(i_CS),
    .level_o(cs_level), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  spi_rx_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0), .FILTER(1'b0)) u_mosi_sync (
    .clk_i(i_Clk), .rst_ni(i_Rst_L), .pin_i(i_MOSI),
    .level_o(mosi_level), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  assign sample = i_EdgeShape ? sclk_rise : sclk_fall;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATASIZE-1:0]  shift_q, shift_d;
  logic                 excess_q, excess_d;
  logic [WW-1:0]        wait_q, wait_d;
  logic [DATASIZE-1:0]  data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 close;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= WAIT_IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      excess_q <= 1'b0;
      wait_q   <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      excess_q <= excess_d;
      wait_q   <= wait_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    excess_d = excess_q;
    wait_d   = wait_q;
    data_d   = data_q;
    valid_d  = valid_q;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;
    close    = 1'b0;

    if (valid_q && i_Ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      WAIT_IDLE: begin
        if (cs_level) begin
          if (wait_q == WW'(SETTLE - 1)) begin
            state_d = IDLE;
            wait_d  = '0;
          end else begin
            wait_d = wait_q + WW'(1);
          end
        end else begin
          wait_d = '0;
        end
      end
      IDLE: begin
        if (cs_fall) begin
          state_d  = SHIFT;
          cnt_d    = '0;
          shift_d  = '0;
          excess_d = 1'b0;
        end
      end
      SHIFT: begin
        if (sample) begin
          shift_d = {shift_q[DATASIZE-2:0], mosi_level};
          cnt_d   = cnt_q + CW'(1);
          if (cnt_d == CW'(DATASIZE)) begin
            state_d = HOLD;
          end
        end
        close = cs_rise;
      end
      HOLD: begin
        if (sample) begin
          excess_d = 1'b1;
        end
        close = cs_rise;
      end
      default: state_d = WAIT_IDLE;
    endcase

    // Close sees the post-edge count, so a sample coincident with CS rising is included.
    if (close) begin
      state_d = IDLE;
      if (cnt_d == CW'(DATASIZE) && !excess_d) begin
        if (!valid_q || i_Ready) begin
          data_d  = shift_d;
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
      end else begin
        ferr_d = 1'b1;
      end
    end
  end

  assign o_Data     = data_q;
  assign o_Valid    = valid_q;
  assign o_FrameErr = ferr_q;
  assign o_Overrun  = ovr_q;
  assign o_Busy     = (state_q == SHIFT) || (state_q == HOLD);

endmodule

// File: doc/spi_receive_deserializer.md
# spi_receive_deserializer

SPI slave receiver on the wireless receiver side that consumes the serial stream produced by the team's SPI transmitter (SCLK/MOSI/CS, MSB first, DATASIZE-bit frames). It oversamples the three asynchronous SPI pins on the local system clock, deserializes one word per CS-low frame and presents it on a valid/ready output port. Malformed frames and words dropped because the consumer stalled are flagged.

## Interface
- DATASIZE, 16, bits per frame; MSB received first
- SYNC_STAGES, 2, flip-flop depth of pin synchronizers (≥2)

- i_Clk  input  1  system clock; all logic on rising edge
- i_Rst_L  input  1  asynchronous, active-low reset
- i_SCLK  input  1  SPI clock pin, asynchronous to i_Clk
- i_MOSI  input  1  SPI data pin, asynchronous
- i_CS  input  1  SPI chip select pin, active low, asynchronous
- i_EdgeShape  input  1  sample edge: 1 = SCLK rising, 0 = SCLK falling; static during a frame
- i_Ready  input  1  downstream accepts o_Data when high with o_Valid
- o_Data  output  DATASIZE  received word, bit DATASIZE-1 = first bit on the wire
- o_Valid  output  1  o_Data holds an unconsumed word
- o_FrameErr  output  1  one-cycle pulse: frame closed with bit count ≠ DATASIZE
- o_Overrun  output  1  one-cycle pulse: complete word dropped because o_Valid still high
- o_Busy  output  1  high while a frame is open (state SHIFT or HOLD)

## Operation
- Reset values: o_Data=0, o_Valid=0, o_FrameErr=0, o_Overrun=0, o_Busy=0; shift register, bit counter cleared; synchronizer stages load 1 for CS, 0 for SCLK/MOSI; state WAIT_IDLE.
- All three pins pass through SYNC_STAGES synchronizers; SCLK and CS feed edge detectors on the synchronized value. Sample edge = synchronized SCLK transition to level i_EdgeShape.
- States:
  - WAIT_IDLE: entered from reset; leave to IDLE only after synchronized CS observed high. A frame already in progress at reset release is ignored.
  - IDLE: CS falling edge → SHIFT, counter=0, shift register=0.
  - SHIFT: each sample edge shifts synchronized MOSI into LSB, counter+1. Counter reaching DATASIZE → HOLD. CS rising edge → close frame.
  - HOLD: further sample edges set an internal excess flag (no shift). CS rising edge → close frame.
- Frame close (→ IDLE): count==DATASIZE and no excess → commit word; otherwise pulse o_FrameErr, discard. Zero-bit frame (CS low then high, no edges) also pulses o_FrameErr.
- Commit: if o_Valid==0 or (o_Valid && i_Ready) in the same cycle, load o_Data, o_Valid=1; else keep old word, pulse o_Overrun.
- Handshake: o_Valid clears on the cycle after o_Valid && i_Ready with no commit; o_Data stable while o_Valid high.
- Sample edge coincident with CS rising edge (same synchronized cycle): edge is counted before close evaluation.
- Counter width $clog2(DATASIZE+1); saturates at DATASIZE.

## Timing
- SCLK high and low phases each ≥ 2 i_Clk periods (≥ 4 with filter); CS high between frames ≥ 2 periods.
- MOSI stable from SCLK setup edge through SYNC_STAGES+1 cycles after sample edge (transmitter changes MOSI on the opposite edge, satisfying this).
- Latency: CS rising at pin → o_Valid high = SYNC_STAGES+2 i_Clk rising edges.
- o_FrameErr/o_Overrun assert on the same cycle o_Valid would have.
- o_Busy rises SYNC_STAGES+2 cycles after CS falling at pin.

## Configuration
- SPI_RX_GLITCH_FILTER_EN defined: SCLK and CS synchronized values accepted only after 3 consecutive identical samples; all pin-to-output latencies +2 cycles; MOSI delayed to match.
- Undefined: no filter; edges taken directly from the last synchronizer stage.

## Structure
- Package spi_rx_pkg: state enum (WAIT_IDLE, IDLE, SHIFT, HOLD), default DATASIZE, filter depth constant.
- Sub-module spi_rx_pin_sync: synchronizer, optional filter, rise/fall pulses; instantiated for SCLK and CS, plain-sync mode for MOSI.

## Test plan
- EdgeShape=1, frame 0xA5C3, i_Ready=1 → o_Data=0xA5C3, one-cycle o_Valid, no errors; repeat with EdgeShape=0, 0x1234.
- Frame of 15 bits then CS high → o_FrameErr pulse, o_Valid stays 0; frame of 17 bits → o_FrameErr, o_Data unchanged.
- i_Ready=0, frames 0x0001 then 0x0002 → o_Data=0x0001 held, o_Overrun pulse on second close; i_Ready=1 → 0x0001 consumed.
- Release reset with CS low mid-frame, finish frame, then send 0xBEEF → first frame ignored, only 0xBEEF presented.
- Assert i_Rst_L low after 8 bits of a frame → all outputs 0 immediately; next full frame 0x00FF received correctly.
- With SPI_RX_GLITCH_FILTER_EN, 1-cycle SCLK glitches inside 0x5555 frame → word 0x5555, latency SYNC_STAGES+4.
